// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if: control, pixel handshake and command bus of the 5x5 convolution frame sequencer.
// Signal suffixes are from the sequencer's point of view.
interface conv_frame_ctrl_if #(
    parameter int WW = 13,
    parameter int HW = 13,
    parameter int KW = 8
);
    logic          start_i;
    logic [WW-1:0] cfg_w_i;
    logic [HW-1:0] cfg_h_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          in_vld_i;
    logic          in_rdy_o;
    logic          cmd_vld_o;
    logic          cmd_rdy_i;
    logic          cmd_push_o;
    logic          cmd_ctr_vld_o;
    logic [KW-1:0] cmd_pos_o;
    logic          cmd_last_o;

    modport slave (
        input  start_i, cfg_w_i, cfg_h_i, in_vld_i, cmd_rdy_i,
        output busy_o, done_o, err_o, in_rdy_o, cmd_vld_o, cmd_push_o, cmd_ctr_vld_o, cmd_pos_o, cmd_last_o
    );

    modport master (
        output start_i, cfg_w_i, cfg_h_i, in_vld_i, cmd_rdy_i,
        input  busy_o, done_o, err_o, in_rdy_o, cmd_vld_o, cmd_push_o, cmd_ctr_vld_o, cmd_pos_o, cmd_last_o
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: raster frame sequencer issuing push/flush window commands with centre position flags.
// The window centre trails the newest pixel by L = 2*W+2 beats; the flush phase drains those L beats.
module conv_frame_ctrl #(
    parameter int IMAGE_MAX_W = 4096,
    parameter int IMAGE_MAX_H = 4096
) (
    input  logic             clk,
    input  logic             rst,
    conv_frame_ctrl_if.slave bus
);
    localparam int WW = $clog2(IMAGE_MAX_W + 1);
    localparam int HW = $clog2(IMAGE_MAX_H + 1);
    localparam int LW = WW + 1;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] w_q, w_d, px_q, px_d, cx_q, cx_d;
    logic [HW-1:0] h_q, h_d, py_q, py_d, cy_q, cy_d;
    logic [LW-1:0] lag_q, lag_d, lag_len;
    logic          done_q, err_q;
    logic          busy, cmd_vld, beat, ctr_vld, last, legal, px_wrap, cx_wrap;
    logic [7:0]    pos;

    assign legal   = (bus.cfg_w_i != '0) && (bus.cfg_w_i <= WW'(IMAGE_MAX_W)) &&
                     (bus.cfg_h_i != '0) && (bus.cfg_h_i <= HW'(IMAGE_MAX_H));
    assign busy    = (state_q == FEED) || (state_q == FLUSH);
    assign cmd_vld = (state_q == FEED) ? bus.in_vld_i : (state_q == FLUSH);
    assign beat    = cmd_vld && bus.cmd_rdy_i;
    assign lag_len = {w_q, 1'b0} + LW'(2);
    assign ctr_vld = busy && (lag_q == lag_len);
    assign px_wrap = px_q == w_q - WW'(1);
    assign cx_wrap = cx_q == w_q - WW'(1);
    assign last    = ctr_vld && cx_wrap && (cy_q == h_q - HW'(1));

    // Bit order {w2,w1,e2,e1,n2,n1,s2,s1}; widened compares keep cx+2 from wrapping at max width.
    assign pos = {cx_q < WW'(2), cx_q < WW'(1),
                  LW'(cx_q) + LW'(2) >= LW'(w_q), LW'(cx_q) + LW'(1) >= LW'(w_q),
                  cy_q < HW'(2), cy_q < HW'(1),
                  (HW+1)'(cy_q) + (HW+1)'(2) >= (HW+1)'(h_q), (HW+1)'(cy_q) + (HW+1)'(1) >= (HW+1)'(h_q)};

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        px_d    = px_q;
        py_d    = py_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        lag_d   = lag_q;
        case (state_q)
            IDLE: if (bus.start_i && legal) begin
                state_d = FEED;
                w_d     = bus.cfg_w_i;
                h_d     = bus.cfg_h_i;
                px_d    = '0;
                py_d    = '0;
                cx_d    = '0;
                cy_d    = '0;
                lag_d   = '0;
            end
            FEED: if (beat) begin
                px_d = px_wrap ? '0 : px_q + WW'(1);
                py_d = px_wrap ? py_q + HW'(1) : py_q;
                if (px_wrap && (py_q == h_q - HW'(1))) state_d = FLUSH;
            end
            FLUSH: if (beat && last) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (beat && !ctr_vld) lag_d = lag_q + LW'(1);
        if (beat && ctr_vld) begin
            cx_d = cx_wrap ? '0 : cx_q + WW'(1);
            cy_d = cx_wrap ? cy_q + HW'(1) : cy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            px_q    <= '0;
            py_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            lag_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            px_q    <= px_d;
            py_q    <= py_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            lag_q   <= lag_d;
            done_q  <= state_d == DONE;
            err_q   <= (state_q == IDLE) && bus.start_i && !legal;
        end
    end

    assign bus.busy_o        = busy;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;
    assign bus.in_rdy_o      = (state_q == FEED) && bus.cmd_rdy_i;
    assign bus.cmd_vld_o     = cmd_vld;
    assign bus.cmd_push_o    = state_q == FEED;
    assign bus.cmd_ctr_vld_o = ctr_vld;
    assign bus.cmd_pos_o     = ctr_vld ? pos : 8'h00;
    assign bus.cmd_last_o    = last;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: directed scenario bench for the frame sequencer.
// Per-beat expectations come from a beat-index model of the raster centre walk.
module tb_conv_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total_n = 0;
    int   bad_n   = 0;

    conv_frame_ctrl_if bus ();

    conv_frame_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mpos(input int w, input int h, input int cx, input int cy);
        return {cx < 2, cx < 1, cx + 2 >= w, cx + 1 >= w, cy < 2, cy < 1, cy + 2 >= h, cy + 1 >= h};
    endfunction

    task automatic test_reset();
        bus.start_i = 0; bus.cfg_w_i = '0; bus.cfg_h_i = '0; bus.in_vld_i = 0; bus.cmd_rdy_i = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        total_n++;
        if ({bus.busy_o, bus.done_o, bus.err_o, bus.in_rdy_o, bus.cmd_vld_o} !== 5'b0) begin
            bad_n++;
            $display("FAIL reset_ctl got=%b want=00000", {bus.busy_o, bus.done_o, bus.err_o, bus.in_rdy_o, bus.cmd_vld_o});
        end
        total_n++;
        if ({bus.cmd_push_o, bus.cmd_ctr_vld_o, bus.cmd_pos_o, bus.cmd_last_o} !== 11'b0) begin
            bad_n++;
            $display("FAIL reset_fields got=%h want=0", {bus.cmd_push_o, bus.cmd_ctr_vld_o, bus.cmd_pos_o, bus.cmd_last_o});
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_frame(input string tag, input int w, input int h, input bit stall);
        int  n, lag, k, cycles, c;
        bit  hold, ectr, elast;
        logic [7:0] ep;
        n = w * h; lag = 2 * w + 2; k = 0; cycles = 0; hold = 0;
        @(negedge clk);
        bus.start_i = 1; bus.cfg_w_i = 13'(w); bus.cfg_h_i = 13'(h);
        @(negedge clk);
        bus.start_i = 0;
        while (k < n + lag && cycles < 4 * (n + lag) + 100) begin
            bus.in_vld_i  = hold || !stall || ($urandom_range(0, 2) != 0);
            bus.cmd_rdy_i = !stall || ($urandom_range(0, 2) != 0);
            #1;
            ectr  = k >= lag;
            c     = ectr ? k - lag : 0;
            elast = k == n + lag - 1;
            ep    = ectr ? mpos(w, h, c % w, c / w) : 8'h00;
            total_n++;
            if (bus.cmd_vld_o !== ((k < n) ? bus.in_vld_i : 1'b1)) begin
                bad_n++;
                $display("FAIL %s cmd_vld beat=%0d got=%b", tag, k, bus.cmd_vld_o);
            end
            total_n++;
            if (bus.in_rdy_o !== ((k < n) && bus.cmd_rdy_i)) begin
                bad_n++;
                $display("FAIL %s in_rdy beat=%0d got=%b", tag, k, bus.in_rdy_o);
            end
            if (bus.cmd_vld_o) begin
                total_n++;
                if ({bus.busy_o, bus.cmd_push_o, bus.cmd_ctr_vld_o, bus.cmd_last_o} !== {1'b1, k < n, ectr, elast}) begin
                    bad_n++;
                    $display("FAIL %s flags beat=%0d got=%b want=%b", tag, k,
                             {bus.busy_o, bus.cmd_push_o, bus.cmd_ctr_vld_o, bus.cmd_last_o}, {1'b1, k < n, ectr, elast});
                end
                total_n++;
                if (bus.cmd_pos_o !== ep) begin
                    bad_n++;
                    $display("FAIL %s pos beat=%0d got=%h want=%h", tag, k, bus.cmd_pos_o, ep);
                end
            end
            hold = (k < n) && bus.in_vld_i && !bus.cmd_rdy_i;
            if (bus.cmd_vld_o && bus.cmd_rdy_i) k++;
            cycles++;
            @(negedge clk);
        end
        total_n++;
        if (k != n + lag) begin
            bad_n++;
            $display("FAIL %s beat_count got=%0d want=%0d", tag, k, n + lag);
        end
        bus.in_vld_i = 0; bus.cmd_rdy_i = 0;
        #1;
        total_n++;
        if ({bus.done_o, bus.busy_o, bus.cmd_vld_o} !== 3'b100) begin
            bad_n++;
            $display("FAIL %s done_pulse got=%b want=100", tag, {bus.done_o, bus.busy_o, bus.cmd_vld_o});
        end
        @(negedge clk);
        #1;
        total_n++;
        if (bus.done_o !== 1'b0) begin
            bad_n++;
            $display("FAIL %s done_clear got=%b want=0", tag, bus.done_o);
        end
    endtask

    task automatic test_illegal();
        logic [25:0] cfgs [3];
        cfgs[0] = {13'd0, 13'd4};
        cfgs[1] = {13'd8, 13'd4097};
        cfgs[2] = {13'd4097, 13'd1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start_i = 1; bus.cfg_w_i = cfgs[i][25:13]; bus.cfg_h_i = cfgs[i][12:0];
            bus.in_vld_i = 1; bus.cmd_rdy_i = 1;
            @(negedge clk);
            bus.start_i = 0;
            #1;
            total_n++;
            if ({bus.err_o, bus.busy_o, bus.cmd_vld_o} !== 3'b100) begin
                bad_n++;
                $display("FAIL illegal_%0d err got=%b want=100", i, {bus.err_o, bus.busy_o, bus.cmd_vld_o});
            end
            @(negedge clk);
            #1;
            total_n++;
            if ({bus.err_o, bus.busy_o, bus.cmd_vld_o} !== 3'b000) begin
                bad_n++;
                $display("FAIL illegal_%0d after got=%b want=000", i, {bus.err_o, bus.busy_o, bus.cmd_vld_o});
            end
        end
        bus.in_vld_i = 0; bus.cmd_rdy_i = 0;
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus.start_i = 1; bus.cfg_w_i = 13'd8; bus.cfg_h_i = 13'd4;
        @(negedge clk);
        bus.start_i = 0; bus.in_vld_i = 1; bus.cmd_rdy_i = 1;
        repeat (20) @(negedge clk);
        #1;
        total_n++;
        if ({bus.busy_o, bus.cmd_push_o, bus.cmd_ctr_vld_o} !== 3'b111) begin
            bad_n++;
            $display("FAIL rst_mid before got=%b want=111", {bus.busy_o, bus.cmd_push_o, bus.cmd_ctr_vld_o});
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        total_n++;
        if ({bus.busy_o, bus.cmd_vld_o, bus.done_o, bus.in_rdy_o} !== 4'b0000) begin
            bad_n++;
            $display("FAIL rst_mid after got=%b want=0000", {bus.busy_o, bus.cmd_vld_o, bus.done_o, bus.in_rdy_o});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            total_n++;
            if ({bus.done_o, bus.busy_o} !== 2'b00) begin
                bad_n++;
                $display("FAIL rst_mid idle_%0d got=%b want=00", i, {bus.done_o, bus.busy_o});
            end
        end
        bus.in_vld_i = 0; bus.cmd_rdy_i = 0;
    endtask

    initial begin
        test_reset();
        test_frame("f8x4", 8, 4, 1'b0);
        test_frame("f1x1", 1, 1, 1'b0);
        test_frame("f5x5_stall", 5, 5, 1'b1);
        test_frame("f5x5", 5, 5, 1'b0);
        test_illegal();
        test_rst_mid();
        test_frame("f8x4_again", 8, 4, 1'b0);
        test_frame("f4096x2", 4096, 2, 1'b0);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
